data_mem_responder: RTL and testbench

Responder end of the processor's load/store data port: accepts one memory request at a time over a valid/ready handshake. Holds the data storage internally. Performs byte/halfword/word stores and sign- or zero-extended loads selected by the funct3-style size code. Returns a response after a programmable number of wait states. Replaces the zero-latency data memory when the memory stage moves to a stallable handshake.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/lsu_align.sv | 52 +++++
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access size codes, FSM states
// and a legality check for the size field.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    function automatic logic size_legal(input logic [2:0] size);
        case (size)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: store byte enables/replicated data and
// load extraction with sign or zero extension.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Store data is replicated across lanes so byte enables alone pick the target.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        misalign   = 1'b0;
        load_data  = 32'h0;
        case (size)
            MEM_B, MEM_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = (size == MEM_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            end
            MEM_H, MEM_HU: begin
                misalign   = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = (size == MEM_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
            end
            MEM_W: begin
                misalign   = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                load_data  = rword;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Stallable data memory: one request at a time over valid/ready, fixed wait
// states, byte-lane storage, registered response held until accepted.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    mem_state_e  state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        req_ready_reg;
    logic [31:0] addr_reg;
    logic        wr_reg;
    logic [2:0]  size_reg;
    logic [31:0] wdata_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic        accept;
    logic        enter_resp;
    logic        use_live;
    logic [31:0] cur_addr;
    logic        cur_wr;
    logic [2:0]  cur_size;
    logic [31:0] cur_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic        misalign;
    logic [31:0] load_data;
    logic        req_err;
    logic        commit_we;

    assign accept     = (state_reg == ST_IDLE) && req_ready_reg && req_valid;
    assign enter_resp = (WAIT_CYCLES == 0) ? accept
                                           : ((state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0));

    // With zero wait states the access happens on the accept edge itself,
    // before the request latches are loaded, so the live inputs are used then.
    always_comb begin
        use_live  = (state_reg == ST_IDLE);
        cur_addr  = use_live ? req_addr  : addr_reg;
        cur_wr    = use_live ? req_wr    : wr_reg;
        cur_size  = use_live ? req_size  : size_reg;
        cur_wdata = use_live ? req_wdata : wdata_reg;
    end

    assign word_idx  = cur_addr[AW+1:2];
    assign req_err   = !size_legal(cur_size) || misalign || ({1'b0, cur_addr} >= ADDR_LIMIT);
    assign commit_we = enter_resp && cur_wr && !req_err;

    lsu_align u_align (
        .addr_lo    (cur_addr[1:0]),
        .size       (cur_size),
        .wdata      (cur_wdata),
        .rword      (rd_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .misalign   (misalign),
        .load_data  (load_data)
    );

    // One storage array per byte lane; contents are not touched by reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [0:DEPTH_WORDS-1];

            always_ff @(posedge clock) begin
                if (commit_we && byte_en[gi]) begin
                    mem_lane[word_idx] <= wdata_lane[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem_lane[word_idx];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 4'd0;
            req_ready_reg <= 1'b0;
            addr_reg      <= 32'h0;
            wr_reg        <= 1'b0;
            size_reg      <= 3'b000;
            wdata_reg     <= 32'h0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        addr_reg      <= req_addr;
                        wr_reg        <= req_wr;
                        size_reg      <= req_size;
                        wdata_reg     <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (enter_resp) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= req_err;
                rsp_rdata_reg <= (req_err || cur_wr) ? 32'h0 : load_data;
            end
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference model checked every
// response cycle, plus literal expectations for each directed transaction.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_wr = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic [31:0] z_req_addr = 32'h0;
    logic        z_req_wr = 1'b0;
    logic [2:0]  z_req_size = 3'b000;
    logic [31:0] z_req_wdata = 32'h0;
    logic        z_rsp_valid;
    logic        z_rsp_ready = 1'b0;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clock(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_z (
        .clock(clk), .reset(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
        .req_wr(z_req_wr), .req_size(z_req_size), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: plain byte-addressed memory with the access rules.
    logic [7:0] mem_m [int];

    function automatic void model_exec(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                                       input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        err = 1'b0;
        rd  = 32'h0;
        n   = 0;
        case (sz)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        err = 1'b1;
        endcase
        if (!err && (a % 32'(n)) != 0) err = 1'b1;
        if (a >= 32'(DEPTH * 4)) err = 1'b1;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < n; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) begin
                if (mem_m.exists(int'(a) + i)) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
            end
            if (sz == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
            if (sz == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end
    endfunction

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        int          acc;
    } req_t;

    req_t q[$];

    // Compare process: every response cycle is checked against the model.
    req_t        cur;
    logic        in_resp = 1'b0;
    logic        m_err;
    logic [31:0] m_rd;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp = 1'b0;
            chk("rst_outputs", {30'h0, req_ready, rsp_valid}, 32'h0);
        end else begin
            if (rsp_valid && req_ready) chk("ready_during_resp", 32'(req_ready), 32'h0);
            if (rsp_valid && !in_resp) begin
                in_resp = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
                    m_rd  = rsp_rdata;
                    m_err = rsp_err;
                end else begin
                    cur = q.pop_front();
                    model_exec(cur.wr, cur.sz, cur.a, cur.wd, m_err, m_rd);
                    chk("model_rdata", rsp_rdata, m_rd);
                    chk("model_err", 32'(rsp_err), 32'(m_err));
                    chk("latency", 32'(cyc - cur.acc), 32'(W));
                end
            end else if (rsp_valid) begin
                chk("hold_rdata", rsp_rdata, m_rd);
                chk("hold_err", 32'(rsp_err), 32'(m_err));
            end
            if (!rsp_valid) in_resp = 1'b0;
        end
    end

    task automatic xact(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, input logic [31:0] lit_rd, input logic lit_err, input string nm);
        int n;
        req_t r;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk({nm, "_req_ready_timeout"}, 32'(req_ready), 32'h1);
            return;
        end
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
        r.wr = wr; r.sz = sz; r.a = a; r.wd = wd; r.acc = cyc + 1;
        q.push_back(r);
        @(negedge clk);
        // Scramble inputs after accept; they must not influence the result.
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = ~wd; req_size = 3'b111; req_wr = ~wr;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            chk({nm, "_rsp_timeout"}, 32'(rsp_valid), 32'h1);
            return;
        end
        chk({nm, "_rdata"}, rsp_rdata, lit_rd);
        chk({nm, "_err"}, 32'(rsp_err), 32'(lit_err));
        $display("xact %s wr=%0b size=%03b addr=%h wdata=%h -> rdata=%h err=%0b",
                 nm, wr, sz, a, wd, rsp_rdata, rsp_err);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_wr = 1'b0; req_size = 3'b010; req_addr = 32'h0;
            @(negedge clk);
            chk({nm, "_hold_req_ready"}, 32'(req_ready), 32'h0);
            chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'h1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_post_valid"}, 32'(rsp_valid), 32'h0);
        chk({nm, "_post_ready"}, 32'(req_ready), 32'h1);
    endtask

    task automatic zx(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] lit_rd, input string nm);
        int n;
        n = 0;
        while (!z_req_ready && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_ready"}, 32'(z_req_ready), 32'h1);
        z_req_valid = 1'b1; z_req_wr = wr; z_req_size = sz; z_req_addr = a; z_req_wdata = wd;
        @(negedge clk);
        z_req_valid = 1'b0;
        chk({nm, "_valid_next_cycle"}, 32'(z_rsp_valid), 32'h1);
        chk({nm, "_rdata"}, z_rsp_rdata, lit_rd);
        chk({nm, "_err"}, 32'(z_rsp_err), 32'h0);
        $display("xact %s wr=%0b size=%03b addr=%h wdata=%h -> rdata=%h err=%0b",
                 nm, wr, sz, a, wd, z_rsp_rdata, z_rsp_err);
        z_rsp_ready = 1'b1;
        @(negedge clk);
        z_rsp_ready = 1'b0;
        chk({nm, "_post_valid"}, 32'(z_rsp_valid), 32'h0);
        chk({nm, "_post_ready"}, 32'(z_req_ready), 32'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_err", 32'(rsp_err), 32'h0);
        rst_n = 1'b1;
        #1 chk("ready_before_first_edge", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("ready_after_first_edge", 32'(req_ready), 32'h1);

        xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, "SW_10");
        xact(1'b0, 3'b010, 32'h10, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, "LW_10");
        xact(1'b0, 3'b000, 32'h13, 32'h0,         0, 32'hFFFF_FFDE, 1'b0, "LB_13");
        xact(1'b0, 3'b100, 32'h13, 32'h0,         0, 32'h0000_00DE, 1'b0, "LBU_13");
        xact(1'b0, 3'b001, 32'h12, 32'h0,         0, 32'hFFFF_DEAD, 1'b0, "LH_12");
        xact(1'b0, 3'b101, 32'h10, 32'h0,         0, 32'h0000_BEEF, 1'b0, "LHU_10");
        xact(1'b1, 3'b000, 32'h11, 32'h0000_00AA, 0, 32'h0,         1'b0, "SB_11");
        xact(1'b0, 3'b010, 32'h10, 32'h0,         0, 32'hDEAD_AAEF, 1'b0, "LW_10_b");
        xact(1'b1, 3'b001, 32'h12, 32'h0000_1234, 0, 32'h0,         1'b0, "SH_12");
        xact(1'b0, 3'b010, 32'h10, 32'h0,         0, 32'h1234_AAEF, 1'b0, "LW_10_h");

        xact(1'b0, 3'b010, 32'h12,       32'h0,         0, 32'h0, 1'b1, "LW_misalign");
        xact(1'b1, 3'b001, 32'h13,       32'hFFFF_FFFF, 0, 32'h0, 1'b1, "SH_misalign");
        xact(1'b0, 3'b011, 32'h10,       32'h0,         0, 32'h0, 1'b1, "size_011");
        xact(1'b1, 3'b010, 32'(DEPTH*4), 32'h5555_5555, 0, 32'h0, 1'b1, "SW_oor");
        xact(1'b0, 3'b010, 32'h10,       32'h0,         0, 32'h1234_AAEF, 1'b0, "LW_after_err");

        xact(1'b0, 3'b010, 32'h10, 32'h0, 5, 32'h1234_AAEF, 1'b0, "LW_hold5");

        // Abandon a store while it is still in its wait states.
        begin
            int n;
            n = 0;
            while (!req_ready && n < 50) begin @(negedge clk); n++; end
            req_valid = 1'b1; req_wr = 1'b1; req_size = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
            @(negedge clk);
            req_valid = 1'b0;
            rst_n = 1'b0;
            q.delete();
            #1 chk("rst_mid_ready", 32'(req_ready), 32'h0);
            chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            #1 chk("rst_release_ready_low", 32'(req_ready), 32'h0);
            @(negedge clk);
            chk("rst_release_ready_high", 32'(req_ready), 32'h1);
            $display("xact RST_during_SW addr=00000010 abandoned");
        end
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h1234_AAEF, 1'b0, "LW_after_rst");

        zx(1'b1, 3'b010, 32'h8, 32'hCAFE_F00D, 32'h0,         "Z_SW_8");
        zx(1'b0, 3'b101, 32'hA, 32'h0,         32'h0000_CAFE, "Z_LHU_A");
        zx(1'b0, 3'b000, 32'h8, 32'h0,         32'h0000_000D, "Z_LB_8");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
